// File: rtl/board_state_engine.sv
// Authoritative game board: answers piece/move legality queries, applies committed
// moves, tracks piece counts and a sticky winner, and serves a registered cell-read port.
module board_state_engine #(
  parameter int BOARD_W = 8,
  parameter int BOARD_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       req,
  input  logic [1:0] op,
  input  logic       player,
  input  logic [3:0] src_x,
  input  logic [3:0] src_y,
  input  logic [3:0] dst_x,
  input  logic [3:0] dst_y,
  output logic       busy,
  output logic       resp_valid,
  output logic       resp_ok,
  output logic [1:0] winning,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_cell
);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_WRITE, S_WIN, S_RESP} state_t;

  localparam logic [1:0] OP_PIECE  = 2'd0;
  localparam logic [1:0] OP_MOVE   = 2'd1;
  localparam logic [1:0] OP_COMMIT = 2'd2;
  localparam logic [1:0] EMPTY     = 2'b00;
  localparam logic [4:0] CNT_INIT  = 5'(2 * BOARD_W);

  state_t     state, state_nxt;
  // Full 16x16 storage lets 4-bit coordinates index directly; cells outside the board stay empty.
  logic [1:0] board [16][16];
  logic [4:0] cnt0, cnt1;

  logic [1:0] op_p0;
  logic       player_p0;
  logic [3:0] sx_p0, sy_p0, dx_p0, dy_p0;
  logic       ok_p1, jump_p1;
  logic [3:0] mx_p1, my_p1;

  logic       own, legal, step, jump, ok_eval;
  logic [3:0] ax, ay, mx, my;

  function automatic logic in_bounds(input logic [3:0] x, input logic [3:0] y);
    return (int'(x) < BOARD_W) && (int'(y) < BOARD_H);
  endfunction

  function automatic logic [1:0] start_cell(input int x, input int y);
    if (x >= BOARD_W || y >= BOARD_H) return EMPTY;
    if (y < 2) return 2'b01;
    if (y >= BOARD_H - 2) return 2'b10;
    return EMPTY;
  endfunction

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    logic signed [4:0] d;
    d = signed'({1'b0, a}) - signed'({1'b0, b});
    return d[4] ? 4'(-d) : d[3:0];
  endfunction

  function automatic logic [1:0] code_of(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [4:0] dec_sat(input logic [4:0] c);
    return (c == 5'd0) ? c : c - 5'd1;
  endfunction

  // Legality terms from the latched request
  always_comb begin
    ax    = abs_diff(dx_p0, sx_p0);
    ay    = abs_diff(dy_p0, sy_p0);
    mx    = 4'(({1'b0, sx_p0} + {1'b0, dx_p0}) >> 1);
    my    = 4'(({1'b0, sy_p0} + {1'b0, dy_p0}) >> 1);
    own   = in_bounds(sx_p0, sy_p0) && (board[sy_p0][sx_p0] == code_of(player_p0));
    step  = (ax <= 4'd1) && (ay <= 4'd1) && (ax != 4'd0 || ay != 4'd0);
    jump  = ((ax == 4'd2 && ay == 4'd0) || (ax == 4'd0 && ay == 4'd2) ||
             (ax == 4'd2 && ay == 4'd2)) && (board[my][mx] == code_of(!player_p0));
    legal = own && in_bounds(dx_p0, dy_p0) && (board[dy_p0][dx_p0] == EMPTY) && (step || jump);
    case (op_p0)
      OP_PIECE:            ok_eval = own && !winning[1];
      OP_MOVE, OP_COMMIT:  ok_eval = legal && !winning[1];
      default:             ok_eval = 1'b0;
    endcase
  end

  // Stage p0: request latch; stage p1: evaluated result
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      op_p0     <= op;
      player_p0 <= player;
      sx_p0     <= src_x;
      sy_p0     <= src_y;
      dx_p0     <= dst_x;
      dy_p0     <= dst_y;
    end
    if (state == S_EVAL) begin
      ok_p1   <= ok_eval;
      jump_p1 <= jump;
      mx_p1   <= mx;
      my_p1   <= my;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      state   <= S_IDLE;
      cnt0    <= CNT_INIT;
      cnt1    <= CNT_INIT;
      winning <= 2'b00;
      rd_cell <= EMPTY;
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          board[y][x] <= start_cell(x, y);
    end else begin
      state   <= state_nxt;
      rd_cell <= in_bounds(rd_x, rd_y) ? board[rd_y][rd_x] : EMPTY;
      if (state == S_WRITE && ok_p1) begin
        board[sy_p0][sx_p0] <= EMPTY;
        board[dy_p0][dx_p0] <= code_of(player_p0);
        if (jump_p1) begin
          board[my_p1][mx_p1] <= EMPTY;
          if (player_p0) cnt0 <= dec_sat(cnt0);
          else           cnt1 <= dec_sat(cnt1);
        end
      end
      // Counts were updated in S_WRITE, so the opponent's count here is post-capture.
      if (state == S_WIN && ok_p1) begin
        if ((player_p0 ? (dy_p0 == 4'd0) : (dy_p0 == 4'(BOARD_H - 1))) ||
            ((player_p0 ? cnt0 : cnt1) == 5'd0))
          winning <= {1'b1, player_p0};
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    resp_valid = 1'b0;
    resp_ok    = 1'b0;
    case (state)
      S_IDLE:  if (req) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = (op_p0 == OP_COMMIT) ? S_WRITE : S_RESP;
      S_WRITE: state_nxt = S_WIN;
      S_WIN:   state_nxt = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        resp_ok    = ok_p1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_state_engine.sv
// Directed and randomized bench for board_state_engine against a cell-array game model.
module tb_board_state_engine;
  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset, init, req, player;
  logic [1:0] op;
  logic [3:0] src_x, src_y, dst_x, dst_y, rd_x, rd_y;
  logic       busy, resp_valid, resp_ok;
  logic [1:0] winning, rd_cell;

  board_state_engine #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk(clk), .reset(reset), .init(init), .req(req), .op(op), .player(player),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .busy(busy), .resp_valid(resp_valid), .resp_ok(resp_ok), .winning(winning),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mb [H][W];
  int mc0, mc1;
  logic [1:0] mwin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mget(input int x, input int y);
    if (x < 0 || y < 0 || x >= W || y >= H) return 0;
    return mb[y][x];
  endfunction

  task automatic model_reset();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mb[y][x] = (y < 2) ? 1 : ((y >= H - 2) ? 2 : 0);
    mc0 = 2 * W;
    mc1 = 2 * W;
    mwin = 2'b00;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Rules straight from the game: returns expected ok and whether the move is a capture.
  task automatic m_eval(input int o, input int p, input int sx, input int sy, input int dx,
                        input int dy, output bit ok, output bit jmp);
    int ax, ay;
    bit own, step, legal;
    ax    = iabs(dx - sx);
    ay    = iabs(dy - sy);
    own   = (mget(sx, sy) == p + 1);
    step  = ((ax > ay) ? ax : ay) == 1;
    jmp   = ((ax == 2 && ay == 0) || (ax == 0 && ay == 2) || (ax == 2 && ay == 2)) &&
            (mget((sx + dx) / 2, (sy + dy) / 2) == 2 - p);
    legal = own && dx < W && dy < H && mget(dx, dy) == 0 && (step || jmp);
    case (o)
      0:       ok = own && !mwin[1];
      1, 2:    ok = legal && !mwin[1];
      default: ok = 1'b0;
    endcase
  endtask

  task automatic do_req(input int o, input int p, input int sx, input int sy, input int dx,
                        input int dy, input bit pulse);
    bit eok, ejmp;
    int n;
    m_eval(o, p, sx, sy, dx, dy, eok, ejmp);
    @(negedge clk);
    req = 1'b1; op = 2'(o); player = 1'(p);
    src_x = 4'(sx); src_y = 4'(sy); dst_x = 4'(dx); dst_y = 4'(dy);
    @(negedge clk);
    req = pulse;
    check("busy_after_accept", busy, 1);
    n = 1;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      req = 1'b0;
      n++;
    end
    check("resp_latency", n, (o == 2) ? 4 : 2);
    check("resp_ok", resp_ok, eok);
    if (o == 2 && eok) begin
      mb[sy][sx] = 0;
      mb[dy][dx] = p + 1;
      if (ejmp) begin
        mb[(sy + dy) / 2][(sx + dx) / 2] = 0;
        if (p == 0) mc1 = (mc1 > 0) ? mc1 - 1 : 0;
        else        mc0 = (mc0 > 0) ? mc0 - 1 : 0;
      end
      if ((p == 0 && dy == H - 1) || (p == 1 && dy == 0) || (p == 0 ? mc1 : mc0) == 0)
        mwin = {1'b1, 1'(p)};
    end
    check("winning", winning, mwin);
    @(negedge clk);
    check("idle_after_resp", {resp_valid, busy}, 2'b00);
    if (pulse)
      repeat (3) begin
        @(negedge clk);
        check("no_extra_resp", resp_valid, 0);
      end
  endtask

  task automatic rd_check(input int x, input int y);
    @(negedge clk);
    rd_x = 4'(x); rd_y = 4'(y);
    @(negedge clk);
    check($sformatf("rd_cell(%0d,%0d)", x, y), rd_cell, mget(x, y));
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    model_reset();
  endtask

  initial begin
    int p, o, sx, sy, dx, dy, r;
    reset = 1'b1; init = 1'b0; req = 1'b0; op = 2'd0; player = 1'b0;
    src_x = 4'd0; src_y = 4'd0; dst_x = 4'd0; dst_y = 4'd0; rd_x = 4'd0; rd_y = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_ok", resp_ok, 0);
    check("rst_winning", winning, 0);
    check("rst_rd_cell", rd_cell, 0);
    reset = 1'b0;
    model_reset();

    rd_check(0, 7);
    check("rd_start_p1", rd_cell, 2'b10);
    do_req(0, 0, 3, 1, 0, 0, 0);
    do_req(0, 1, 3, 1, 0, 0, 0);
    do_req(1, 0, 2, 1, 2, 2, 0);
    do_req(1, 0, 2, 1, 2, 3, 0);
    do_req(1, 0, 2, 1, 2, 0, 0);
    do_req(1, 0, 7, 1, 8, 2, 0);

    do_req(2, 0, 2, 1, 2, 2, 1);
    rd_check(2, 1);
    rd_check(2, 2);
    check("rd_committed_dst", rd_cell, 2'b01);

    do_req(2, 1, 2, 6, 2, 5, 0);
    do_req(2, 1, 2, 5, 2, 4, 0);
    do_req(2, 1, 2, 4, 2, 3, 0);
    do_req(2, 0, 2, 2, 2, 4, 0);
    rd_check(2, 3);
    check("cnt1_after_jump", dut.cnt1, mc1);
    check("cnt1_value", mc1, 15);

    do_req(2, 1, 2, 7, 2, 6, 0);
    do_req(2, 0, 2, 4, 2, 5, 0);
    do_req(2, 0, 2, 5, 2, 7, 0);
    check("win_p0", winning, 2'b10);
    do_req(0, 0, 3, 1, 0, 0, 0);

    do_init();
    check("init_winning", winning, 0);
    rd_check(2, 1);
    rd_check(2, 7);
    rd_check(2, 4);

    // Reset lands while the COMMIT sits in S_WRITE
    @(negedge clk);
    req = 1'b1; op = 2'd2; player = 1'b0;
    src_x = 4'd3; src_y = 4'd1; dst_x = 4'd3; dst_y = 4'd2;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort_busy", busy, 0);
    check("abort_resp_valid", resp_valid, 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_resp", resp_valid, 0);
    end
    rd_check(3, 1);
    rd_check(3, 2);
    do_req(3, 0, 3, 1, 3, 2, 0);

    for (int i = 0; i < 200; i++) begin
      if (mwin[1] && $urandom_range(0, 2) == 0) do_init();
      p  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      o  = (r < 2) ? 0 : (r < 4) ? 1 : (r < 9) ? 2 : 3;
      if ($urandom_range(0, 9) != 0) begin
        sx = int'($urandom_range(0, W - 1));
        sy = int'($urandom_range(0, H - 1));
      end else begin
        sx = int'($urandom_range(0, 15));
        sy = int'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 4) != 0) begin
        dx = sx + int'($urandom_range(0, 4)) - 2;
        dy = sy + int'($urandom_range(0, 4)) - 2;
        dx = (dx < 0) ? 0 : (dx > 15) ? 15 : dx;
        dy = (dy < 0) ? 0 : (dy > 15) ? 15 : dy;
      end else begin
        dx = int'($urandom_range(0, 15));
        dy = int'($urandom_range(0, 15));
      end
      do_req(o, p, sx, sy, dx, dy, (i % 7) == 3);
      if (i % 5 == 0) begin
        rd_check(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        check("cnt0", dut.cnt0, mc0);
        check("cnt1", dut.cnt1, mc1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_state_engine.md
Name: board_state_engine

Overview:
- Responder side of the game controller's piece/move interface; owns the authoritative board.
- Answers the controller's "is this my piece?" (piece_valid) and "is this a legal destination?" (move_valid) queries.
- Applies committed moves and reports the 2-bit winning status in the controller's {game_over, winner} format.
- Also exposes a registered cell-read port for the display path.

Parameters:
BOARD_W, 8, board width in cells (max 15)
BOARD_H, 8, board height in cells (max 15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
init  in  1  load starting position; same effect as reset on board, counts, FSM, winning
req  in  1  request strobe, sampled only when busy=0
op  in  2  0=CHECK_PIECE, 1=CHECK_MOVE, 2=COMMIT, 3=reserved
player  in  1  requesting player (0/1)
src_x, src_y  in  4  selected piece; origin (0,0) is bottom-left
dst_x, dst_y  in  4  destination cell
busy  out  1  request in flight
resp_valid  out  1  one-cycle response pulse
resp_ok  out  1  result, qualified by resp_valid
winning  out  2  [1]=game over, [0]=winning player
rd_x, rd_y  in  4  display read address
rd_cell  out  2  cell at (rd_x, rd_y), 1-cycle latency

Behaviour:
- Cell encoding: 00 empty, 01 player0, 10 player1; 11 is never stored.
- Start position (after reset or init):
  - Rows 0..1 hold player0; rows BOARD_H-2..BOARD_H-1 hold player1; all other cells empty.
  - cnt0 = cnt1 = 2*BOARD_W.
- Output reset values: busy=0, resp_valid=0, resp_ok=0, winning=00, rd_cell=00; FSM goes to S_IDLE.
- Reset/init priority: reset or init in any cycle overrides everything. An in-flight request is aborted with no resp_valid.
- Request acceptance:
  - req with busy=1 is ignored.
  - In S_IDLE with req=1, latch op/player/src/dst, then go to S_EVAL. busy=1 from the next cycle.
- FSM:
  - S_IDLE -> S_EVAL -> S_RESP -> S_IDLE for CHECK_PIECE, CHECK_MOVE and reserved ops.
  - S_IDLE -> S_EVAL -> S_WRITE -> S_WIN -> S_RESP -> S_IDLE for COMMIT.
  - busy=1 in every state except S_IDLE.
  - resp_valid=1 only in S_RESP.
- Latency:
  - Check ops: req at cycle 0, resp_valid at cycle 2.
  - COMMIT: resp_valid at cycle 4.
  - The next request can be accepted on the cycle after resp_valid.
- S_EVAL registers the legality terms:
  - in-bounds test: x < BOARD_W and y < BOARD_H.
  - own = src in bounds and src cell == player's code.
  - dx = dst_x - src_x, dy = dst_y - src_y, each 5-bit signed.
  - step = max(|dx|,|dy|) == 1.
  - jump = (|dx|,|dy|) in {(2,0),(0,2),(2,2)}, and the middle cell (src+dst)/2 holds the opponent.
  - legal = own and dst in bounds and dst empty and (step or jump).
- Response value:
  - CHECK_PIECE: resp_ok = own and not winning[1].
  - CHECK_MOVE and COMMIT: resp_ok = legal and not winning[1].
  - Reserved op: resp_ok = 0.
- S_WRITE (only when the COMMIT is ok; otherwise the board is untouched and the FSM still passes through S_WRITE/S_WIN):
  - src <- empty, dst <- player code.
  - If jump: middle cell <- empty, and the opponent's count decrements by 1 (saturating at 0).
- S_WIN (only when the COMMIT is ok): set winning = {1, player} if either holds:
  - player0 landed on row BOARD_H-1, or player1 landed on row 0;
  - the opponent's count is now 0.
- winning is sticky until reset/init. While winning[1]=1 every query returns resp_ok=0.
- rd_cell returns 00 for an out-of-bounds address. It is updated every cycle regardless of FSM state and reflects writes one cycle after S_WRITE.

Test Plan:
- Reset, then CHECK_PIECE p0 (3,1) -> resp_valid exactly at cycle 2 with resp_ok=1; the same query with p1 -> resp_ok=0; rd (0,7) -> rd_cell=10.
- CHECK_MOVE p0 (2,1)->(2,2) -> ok=1; (2,1)->(2,3) with (2,2) empty -> ok=0; (2,1)->(2,0) into an occupied cell -> ok=0; dst (8,2) -> ok=0.
- COMMIT p0 (2,1)->(2,2) -> ok=1 at cycle 4; rd (2,1)=00 and rd (2,2)=01; a req pulsed during busy is ignored, with no extra resp_valid.
- Jump capture: place p1 at (2,3), COMMIT p0 (2,2)->(2,4) -> ok=1; (2,3)=00; cnt1 drops from 16 to 15.
- Win: drive p0 into row 7 via COMMIT -> winning=10 after S_WIN; later CHECK_PIECE -> ok=0; init -> winning=00 and start position restored.
- Reset asserted in S_WRITE of a COMMIT -> no resp_valid, board at start position, busy=0 the next cycle; op=3 -> ok=0 at cycle 2.
